// File: rtl/lifo_pkg.sv
// rtl/lifo_pkg.sv - shared constants, count-width helper and per-cycle operation enum for lifo_stack
package lifo_pkg;

  localparam int LIFO_WIDTH = 8;
  localparam int LIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } op_e;

  function automatic int cw_f(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lifo_ram.sv
// rtl/lifo_ram.sv - DEPTH x WIDTH register array, one write port, one registered read port
module lifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the read register is reset; a same-edge write to raddr returns the old word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - single-pointer LIFO with registered pop data; LIFO_STACK_THRESH_EN adds almost_full/almost_empty
module lifo_stack
  import lifo_pkg::*;
#(
  parameter  int WIDTH = LIFO_WIDTH,
  parameter  int DEPTH = LIFO_DEPTH,
  localparam int CW    = cw_f(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
`ifdef LIFO_STACK_THRESH_EN
  input  logic [CW-1:0]    thresh,
  output logic             almost_full,
  output logic             almost_empty,
`endif
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          pop_ok;
  logic          push_ok;
  op_e           op;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] next_idx;
  logic [AW-1:0] waddr;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

`ifdef LIFO_STACK_THRESH_EN
  // Summed rather than subtracted so a thresh larger than DEPTH cannot wrap.
  assign almost_full  = (int'(count) + int'(thresh)) >= DEPTH;
  assign almost_empty = (count <= thresh);
`endif

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    op = OP_IDLE;
    if (push_ok && pop_ok) begin
      op = OP_REPLACE;
    end else if (push_ok) begin
      op = OP_PUSH;
    end else if (pop_ok) begin
      op = OP_POP;
    end
  end

  assign top_idx  = AW'(count - CW'(1));
  assign next_idx = AW'(count);
  assign waddr    = (op == OP_REPLACE) ? top_idx : next_idx;

  lifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (push_ok),
    .waddr (waddr),
    .wdata (data_in),
    .re    (pop_ok),
    .raddr (top_idx),
    .rdata (data_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      data_valid <= pop_ok;
      overflow   <= push & ~push_ok;
      underflow  <= pop & empty;
      case (op)
        OP_PUSH: count <= count + CW'(1);
        OP_POP:  count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_stack.sv
// tb/tb_lifo_stack.sv - directed self-checking bench for lifo_stack (WIDTH=8, DEPTH=8)
module tb_lifo_stack;
  import lifo_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = cw_f(DEPTH);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
`ifdef LIFO_STACK_THRESH_EN
  logic [CW-1:0]    thresh = '0;
  logic             almost_full;
  logic             almost_empty;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .empty        (empty),
    .full         (full),
    .count        (count),
`ifdef LIFO_STACK_THRESH_EN
    .thresh       (thresh),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`endif
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // One clock with the given operation; outputs are sampled 1ns after the edge.
  task automatic cyc(input op_e op, input logic [WIDTH-1:0] d);
    push    = (op == OP_PUSH) || (op == OP_REPLACE);
    pop     = (op == OP_POP)  || (op == OP_REPLACE);
    data_in = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got=%b exp=1", empty); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got=%b exp=0", full); end
    vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
    vectors++; if ({overflow, underflow} !== 2'b00) begin miscompares++; $display("FAIL reset_pulses got=%b exp=00", {overflow, underflow}); end
  endtask

  task automatic test_order();
    logic [7:0] exp_pop [3];
    exp_pop = '{8'h33, 8'h22, 8'h11};
    cyc(OP_PUSH, 8'h11);
    cyc(OP_PUSH, 8'h22);
    cyc(OP_PUSH, 8'h33);
    vectors++; if (count !== 4'd3) begin miscompares++; $display("FAIL order_count got=%0d exp=3", count); end
    for (int i = 0; i < 3; i++) begin
      cyc(OP_POP, 8'h00);
      vectors++; if (data_out !== exp_pop[i] || data_valid !== 1'b1) begin
        miscompares++; $display("FAIL order_pop%0d got=%h/%b exp=%h/1", i, data_out, data_valid, exp_pop[i]);
      end
    end
    vectors++; if (empty !== 1'b1 || count !== 4'd0) begin miscompares++; $display("FAIL order_empty got=%b/%0d exp=1/0", empty, count); end
    cyc(OP_IDLE, 8'h00);
    vectors++; if (data_valid !== 1'b0 || data_out !== 8'h11) begin miscompares++; $display("FAIL order_hold got=%h/%b exp=11/0", data_out, data_valid); end
  endtask

  task automatic test_boundary();
    for (int i = 0; i < 8; i++) cyc(OP_PUSH, 8'hA0 + 8'(i));
    vectors++; if (full !== 1'b1 || count !== 4'd8) begin miscompares++; $display("FAIL bnd_full got=%b/%0d exp=1/8", full, count); end
    cyc(OP_PUSH, 8'hFF);
    vectors++; if (overflow !== 1'b1 || count !== 4'd8) begin miscompares++; $display("FAIL bnd_overflow got=%b/%0d exp=1/8", overflow, count); end
    cyc(OP_IDLE, 8'h00);
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL bnd_overflow_pulse got=%b exp=0", overflow); end
    for (int i = 7; i >= 0; i--) begin
      cyc(OP_POP, 8'h00);
      vectors++; if (data_out !== 8'hA0 + 8'(i) || count !== 4'(i)) begin
        miscompares++; $display("FAIL bnd_pop%0d got=%h/%0d exp=%h/%0d", i, data_out, count, 8'hA0 + 8'(i), i);
      end
    end
    cyc(OP_POP, 8'h00);
    vectors++; if (underflow !== 1'b1 || data_valid !== 1'b0 || data_out !== 8'hA0) begin
      miscompares++; $display("FAIL bnd_underflow got=%b/%b/%h exp=1/0/a0", underflow, data_valid, data_out);
    end
    cyc(OP_IDLE, 8'h00);
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL bnd_underflow_pulse got=%b exp=0", underflow); end
  endtask

  task automatic test_replace();
    cyc(OP_PUSH, 8'h01);
    cyc(OP_PUSH, 8'h02);
    cyc(OP_REPLACE, 8'h09);
    vectors++; if (data_out !== 8'h02 || data_valid !== 1'b1 || count !== 4'd2) begin
      miscompares++; $display("FAIL rep_mid got=%h/%b/%0d exp=02/1/2", data_out, data_valid, count);
    end
    cyc(OP_POP, 8'h00);
    vectors++; if (data_out !== 8'h09) begin miscompares++; $display("FAIL rep_mid_pop got=%h exp=09", data_out); end
    cyc(OP_POP, 8'h00);
    vectors++; if (data_out !== 8'h01 || empty !== 1'b1) begin miscompares++; $display("FAIL rep_mid_drain got=%h/%b exp=01/1", data_out, empty); end
    for (int i = 0; i < 8; i++) cyc(OP_PUSH, 8'h30 + 8'(i));
    cyc(OP_REPLACE, 8'h77);
    vectors++; if (overflow !== 1'b0 || data_out !== 8'h37 || count !== 4'd8 || full !== 1'b1) begin
      miscompares++; $display("FAIL rep_full got=%b/%h/%0d/%b exp=0/37/8/1", overflow, data_out, count, full);
    end
    cyc(OP_POP, 8'h00);
    vectors++; if (data_out !== 8'h77) begin miscompares++; $display("FAIL rep_full_pop got=%h exp=77", data_out); end
    for (int i = 0; i < 7; i++) cyc(OP_POP, 8'h00);
    vectors++; if (data_out !== 8'h30 || empty !== 1'b1) begin miscompares++; $display("FAIL rep_full_drain got=%h/%b exp=30/1", data_out, empty); end
    cyc(OP_REPLACE, 8'h5A);
    vectors++; if (underflow !== 1'b1 || count !== 4'd1 || data_valid !== 1'b0 || data_out !== 8'h30) begin
      miscompares++; $display("FAIL rep_empty got=%b/%0d/%b/%h exp=1/1/0/30", underflow, count, data_valid, data_out);
    end
    cyc(OP_POP, 8'h00);
    vectors++; if (data_out !== 8'h5A || data_valid !== 1'b1) begin miscompares++; $display("FAIL rep_empty_pop got=%h/%b exp=5a/1", data_out, data_valid); end
  endtask

  task automatic test_async_reset();
    cyc(OP_PUSH, 8'h44);
    cyc(OP_PUSH, 8'h55);
    cyc(OP_POP, 8'h00);
    vectors++; if (data_valid !== 1'b1 || count !== 4'd1) begin miscompares++; $display("FAIL arst_pre got=%b/%0d exp=1/1", data_valid, count); end
    reset = 1'b0;
    #2;
    vectors++; if (data_valid !== 1'b0 || count !== 4'd0 || data_out !== 8'h00) begin
      miscompares++; $display("FAIL arst_async got=%b/%0d/%h exp=0/0/00", data_valid, count, data_out);
    end
    #1;
    reset = 1'b1;
    cyc(OP_POP, 8'h00);
    vectors++; if (underflow !== 1'b1 || data_valid !== 1'b0) begin miscompares++; $display("FAIL arst_underflow got=%b/%b exp=1/0", underflow, data_valid); end
  endtask

`ifdef LIFO_STACK_THRESH_EN
  task automatic test_thresh();
    thresh = 4'd2;
    #1;
    vectors++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin miscompares++; $display("FAIL thr_c0 got=%b/%b exp=1/0", almost_empty, almost_full); end
    for (int c = 1; c <= 8; c++) begin
      cyc(OP_PUSH, 8'(c));
      vectors++; if (almost_empty !== (c <= 2) || almost_full !== (c >= 6)) begin
        miscompares++; $display("FAIL thr_c%0d got=%b/%b exp=%b/%b", c, almost_empty, almost_full, c <= 2, c >= 6);
      end
    end
    for (int i = 0; i < 8; i++) cyc(OP_POP, 8'h00);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_order();
    test_boundary();
    test_replace();
    test_async_reset();
`ifdef LIFO_STACK_THRESH_EN
    test_thresh();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
